crossbar_packet_arbiter: RTL and testbench

Packet-level arbiter for the Scheduler's AXI-stream crossbar. Watches every RX input's tvalid/tdest/tlast and each input's beat acceptance, and grants each output FIFO to at most one input at a time. Grants use round-robin order and stay locked until that packet's tlast beat is accepted. The crossbar consumes the registered per-output select and per-input grant vectors to steer data and gate tready.

---
 rtl/crossbar_arb_pkg.sv | 17 +
 rtl/crossbar_packet_arbiter_rr_pick.sv | 27 ++
 rtl/crossbar_packet_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_crossbar_packet_arbiter.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crossbar_arb_pkg.sv
// Shared definitions for the crossbar packet arbiter: per-output state
// encoding, select-width helper and the default watchdog timeout.
package crossbar_arb_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    localparam int WD_TIMEOUT_DEFAULT = 1024;

    // Width of an input index; never narrower than one bit.
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/crossbar_packet_arbiter_rr_pick.sv
// Combinational cyclic priority picker: returns the first set request bit
// at or after ptr, wrapping around, plus a found flag.
module rr_pick #(
    parameter int N    = 3,
    parameter int SELW = 2
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic            found,
    output logic [SELW-1:0] idx
);

    // Scan from the farthest offset down so the nearest offset (k = 0) wins last.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            logic [SELW-1:0] cand;
            cand = SELW'((int'(ptr) + k) % N);
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/crossbar_packet_arbiter.sv
// Packet-level arbiter for the AXI-stream crossbar. Each output FIFO is
// owned by at most one input from grant until that input's tlast beat is
// accepted; free outputs are re-arbitrated round-robin.
//
// Handshake: s_req_tvalid/tdest/tlast describe the beat each input offers;
// s_req_taccept[i] is the crossbar's tvalid&tready for input i, i.e. the
// beat was transferred this cycle. Only the owner's accept is observed by
// an output; accepts from non-owning inputs are ignored.
//
// Optional feature: define CROSSBAR_ARB_WATCHDOG_EN to build per-output
// stall counters that force an output free after WD_TIMEOUT idle cycles.
module crossbar_packet_arbiter
    import crossbar_arb_pkg::*;
#(
    parameter int IF_COUNT_DOWN_RX = 3,
    parameter int OUT_COUNT        = 3,
    parameter int AXIS_DEST_WIDTH  = 9,
    parameter int WD_TIMEOUT       = WD_TIMEOUT_DEFAULT
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic [IF_COUNT_DOWN_RX-1:0]                     s_req_tvalid,
    input  logic [IF_COUNT_DOWN_RX*AXIS_DEST_WIDTH-1:0]     s_req_tdest,
    input  logic [IF_COUNT_DOWN_RX-1:0]                     s_req_tlast,
    input  logic [IF_COUNT_DOWN_RX-1:0]                     s_req_taccept,
    output logic [OUT_COUNT-1:0]                            m_grant_valid,
    output logic [OUT_COUNT*sel_width(IF_COUNT_DOWN_RX)-1:0] m_grant_sel,
    output logic [IF_COUNT_DOWN_RX-1:0]                     m_in_grant,
    output logic [IF_COUNT_DOWN_RX-1:0]                     dest_err,
    output logic [OUT_COUNT-1:0]                            wd_release
);

    localparam int N    = IF_COUNT_DOWN_RX;
    localparam int M    = OUT_COUNT;
    localparam int DW   = AXIS_DEST_WIDTH;
    localparam int SELW = sel_width(N);

    arb_state_t      state_q [M];
    logic [SELW-1:0] sel_q   [M];
    logic [SELW-1:0] ptr_q   [M];

    logic [DW-1:0]   tdest   [N];
    logic [N-1:0]    req     [M];
    logic [M-1:0]    found;
    logic [SELW-1:0] pick    [M];
    logic [N-1:0]    claimed;
    logic [M-1:0]    grant_now;
    logic [M-1:0]    release_now;
    logic [M-1:0]    wd_fire;
    logic [N-1:0]    in_grant_d;
    logic [N-1:0]    dest_err_d;

    // Unpack tdest and build per-output request vectors from ungranted inputs.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            tdest[i] = s_req_tdest[i*DW +: DW];
        end
        for (int j = 0; j < M; j++) begin
            for (int i = 0; i < N; i++) begin
                req[j][i] = s_req_tvalid[i] && (tdest[i] == DW'(j)) && !m_in_grant[i];
            end
        end
    end

    for (genvar j = 0; j < M; j++) begin : g_pick
        rr_pick #(
            .N    (N),
            .SELW (SELW)
        ) u_rr_pick (
            .req   (req[j]),
            .ptr   (ptr_q[j]),
            .found (found[j]),
            .idx   (pick[j])
        );
    end

    // Resolve grants in ascending output order so an input is never granted twice.
    always_comb begin
        claimed   = '0;
        grant_now = '0;
        for (int j = 0; j < M; j++) begin
            if (state_q[j] == ARB_IDLE && found[j] && !claimed[pick[j]]) begin
                grant_now[j]     = 1'b1;
                claimed[pick[j]] = 1'b1;
            end
        end
    end

    // A locked output frees on the owner's accepted tlast beat or a watchdog expiry.
    always_comb begin
        for (int j = 0; j < M; j++) begin
            release_now[j] = (state_q[j] == ARB_LOCKED) &&
                             ((s_req_taccept[sel_q[j]] && s_req_tlast[sel_q[j]]) || wd_fire[j]);
        end
    end

    // Next-cycle ownership per input and bad-destination detection.
    always_comb begin
        in_grant_d = '0;
        dest_err_d = '0;
        for (int j = 0; j < M; j++) begin
            for (int i = 0; i < N; i++) begin
                if ((state_q[j] == ARB_LOCKED && !release_now[j] && sel_q[j] == SELW'(i)) ||
                    (grant_now[j] && pick[j] == SELW'(i))) begin
                    in_grant_d[i] = 1'b1;
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            dest_err_d[i] = s_req_tvalid[i] && ({1'b0, tdest[i]} >= (DW+1)'(M)) && !m_in_grant[i];
        end
    end

`ifdef CROSSBAR_ARB_WATCHDOG_EN
    localparam int CW = $clog2(WD_TIMEOUT);

    logic [CW-1:0] wd_cnt_q [M];

    // Expire when the owner has gone WD_TIMEOUT cycles without an accepted beat.
    always_comb begin
        for (int j = 0; j < M; j++) begin
            wd_fire[j] = (state_q[j] == ARB_LOCKED) && !s_req_taccept[sel_q[j]] &&
                         (wd_cnt_q[j] == CW'(WD_TIMEOUT - 1));
        end
    end

    // Stall counter: counts locked cycles without an owner accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < M; j++) begin
                wd_cnt_q[j] <= '0;
            end
        end else begin
            for (int j = 0; j < M; j++) begin
                if (state_q[j] != ARB_LOCKED || release_now[j] || s_req_taccept[sel_q[j]]) begin
                    wd_cnt_q[j] <= '0;
                end else begin
                    wd_cnt_q[j] <= wd_cnt_q[j] + CW'(1);
                end
            end
        end
    end
`else
    assign wd_fire = '0;
`endif

    // Per-output IDLE/LOCKED state machine with registered grant outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < M; j++) begin
                state_q[j] <= ARB_IDLE;
                sel_q[j]   <= '0;
                ptr_q[j]   <= '0;
            end
            m_grant_valid <= '0;
            m_in_grant    <= '0;
            dest_err      <= '0;
            wd_release    <= '0;
        end else begin
            for (int j = 0; j < M; j++) begin
                case (state_q[j])
                    ARB_IDLE: begin
                        if (grant_now[j]) begin
                            state_q[j]       <= ARB_LOCKED;
                            sel_q[j]         <= pick[j];
                            ptr_q[j]         <= (pick[j] == SELW'(N - 1)) ? '0 : pick[j] + SELW'(1);
                            m_grant_valid[j] <= 1'b1;
                        end
                    end
                    ARB_LOCKED: begin
                        if (release_now[j]) begin
                            state_q[j]       <= ARB_IDLE;
                            m_grant_valid[j] <= 1'b0;
                        end
                    end
                    default: begin
                        state_q[j]       <= ARB_IDLE;
                        m_grant_valid[j] <= 1'b0;
                    end
                endcase
            end
            m_in_grant <= in_grant_d;
            dest_err   <= dest_err_d;
            wd_release <= wd_fire;
        end
    end

    // Pack the registered selects onto the output bus.
    always_comb begin
        for (int j = 0; j < M; j++) begin
            m_grant_sel[j*SELW +: SELW] = sel_q[j];
        end
    end

endmodule

// File: tb/tb_crossbar_packet_arbiter.sv
// Self-checking bench for crossbar_packet_arbiter. A behavioural owner/pointer
// model tracks expected grants from the observed inputs each cycle; scenario
// tasks add targeted checks on top of the model comparison.
module tb_crossbar_packet_arbiter;

    localparam int N    = 3;
    localparam int M    = 3;
    localparam int DW   = 9;
    localparam int SELW = 2;
    localparam int WD   = 8;
`ifdef CROSSBAR_ARB_WATCHDOG_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif
    localparam int CMPW = M + M*SELW + 2*N + M;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      s_req_tvalid;
    logic [N*DW-1:0]   s_req_tdest;
    logic [N-1:0]      s_req_tlast;
    logic [N-1:0]      s_req_taccept;
    logic [M-1:0]      m_grant_valid;
    logic [M*SELW-1:0] m_grant_sel;
    logic [N-1:0]      m_in_grant;
    logic [N-1:0]      dest_err;
    logic [M-1:0]      wd_release;

    crossbar_packet_arbiter #(
        .IF_COUNT_DOWN_RX (N),
        .OUT_COUNT        (M),
        .AXIS_DEST_WIDTH  (DW),
        .WD_TIMEOUT       (WD)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_req_tvalid  (s_req_tvalid),
        .s_req_tdest   (s_req_tdest),
        .s_req_tlast   (s_req_tlast),
        .s_req_taccept (s_req_taccept),
        .m_grant_valid (m_grant_valid),
        .m_grant_sel   (m_grant_sel),
        .m_in_grant    (m_in_grant),
        .dest_err      (dest_err),
        .wd_release    (wd_release)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- counters ----------------
    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- reference model state ----------------
    int                own   [M];
    int                ptr   [M];
    int                stall [M];
    logic [M-1:0]      exp_valid;
    logic [M*SELW-1:0] exp_sel;
    logic [N-1:0]      exp_ing;
    logic [N-1:0]      exp_err;
    logic [M-1:0]      exp_wd;
    logic [M*SELW-1:0] obs_sel;
    logic [CMPW-1:0]   obs_all;
    logic [CMPW-1:0]   exp_all;

    always_comb begin
        for (int j = 0; j < M; j++) begin
            obs_sel[j*SELW +: SELW] = m_grant_valid[j] ? m_grant_sel[j*SELW +: SELW] : '0;
        end
    end
    assign obs_all = {m_grant_valid, obs_sel, m_in_grant, dest_err, wd_release};
    assign exp_all = {exp_valid, exp_sel, exp_ing, exp_err, exp_wd};

    // ---------------- packet driver state ----------------
    int beats  [N];
    int plen   [N];
    int pdest  [N];
    bit reload [N];
    bit ready  [N];
    bit raw_mode;

    logic [N-1:0] exp_q [$];

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_update();
        bit busy  [N];
        bit taken [N];
        int nown  [M];
        if (rst) begin
            for (int j = 0; j < M; j++) begin
                own[j] = -1; ptr[j] = 0; stall[j] = 0;
            end
            exp_err = '0;
            exp_wd  = '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                busy[i]  = 1'b0;
                taken[i] = 1'b0;
            end
            for (int j = 0; j < M; j++) if (own[j] >= 0) busy[own[j]] = 1'b1;
            for (int i = 0; i < N; i++) begin
                exp_err[i] = s_req_tvalid[i] && (int'(s_req_tdest[i*DW +: DW]) >= M) && !busy[i];
            end
            for (int j = 0; j < M; j++) begin
                nown[j]   = own[j];
                exp_wd[j] = 1'b0;
                if (own[j] >= 0) begin
                    if (s_req_taccept[own[j]] && s_req_tlast[own[j]]) begin
                        nown[j] = -1; stall[j] = 0;
                    end else if (s_req_taccept[own[j]]) begin
                        stall[j] = 0;
                    end else if (WD_EN && stall[j] == WD - 1) begin
                        nown[j] = -1; stall[j] = 0; exp_wd[j] = 1'b1;
                    end else begin
                        stall[j]++;
                    end
                end else begin
                    stall[j] = 0;
                    for (int k = 0; k < N; k++) begin
                        int c;
                        c = (ptr[j] + k) % N;
                        if (nown[j] < 0 && s_req_tvalid[c] && int'(s_req_tdest[c*DW +: DW]) == j &&
                            !busy[c] && !taken[c]) begin
                            nown[j]  = c;
                            ptr[j]   = (c + 1) % N;
                            taken[c] = 1'b1;
                        end
                    end
                end
            end
            for (int j = 0; j < M; j++) own[j] = nown[j];
        end
        exp_ing = '0;
        for (int j = 0; j < M; j++) begin
            exp_valid[j]             = (own[j] >= 0);
            exp_sel[j*SELW +: SELW]  = (own[j] >= 0) ? SELW'(own[j]) : '0;
            if (own[j] >= 0) exp_ing[own[j]] = 1'b1;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            if (raw_mode) begin
                s_req_tvalid[i]          = 1'($urandom_range(0, 1));
                s_req_tdest[i*DW +: DW]  = ($urandom_range(0, 9) == 0) ? DW'(256 + $urandom_range(0, 2))
                                                                       : DW'($urandom_range(0, 4));
                s_req_tlast[i]           = 1'($urandom_range(0, 1));
                s_req_taccept[i]         = ($urandom_range(0, 3) != 0);
            end else begin
                s_req_tvalid[i]          = (beats[i] > 0);
                s_req_tdest[i*DW +: DW]  = DW'(pdest[i]);
                s_req_tlast[i]           = (beats[i] == 1);
                s_req_taccept[i]         = (beats[i] > 0) && m_in_grant[i] && ready[i];
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        if (!raw_mode) begin
            for (int i = 0; i < N; i++) begin
                if (s_req_taccept[i] && beats[i] > 0) begin
                    beats[i]--;
                    if (beats[i] == 0 && reload[i]) beats[i] = plen[i];
                end
            end
        end
        #1;
        drive_inputs();
    endtask

    task automatic set_pkt(input int i, input int len, input int dest, input bit rl);
        plen[i] = len; beats[i] = len; pdest[i] = dest; reload[i] = rl; ready[i] = 1'b1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        raw_mode = 1'b0;
        for (int i = 0; i < N; i++) begin
            beats[i] = 0; plen[i] = 0; pdest[i] = 0; reload[i] = 1'b0; ready[i] = 1'b1;
        end
        drive_inputs();
        step();
        rst = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        raw_mode = 1'b1;
        drive_inputs();
        for (int k = 0; k < 3; k++) begin
            step();
            if (obs_all !== '0) begin
                n_fail++;
                $display("FAIL reset_state k=%0d got %h want 0", k, obs_all);
            end
            n_tests++;
        end
        raw_mode = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_basic_grant();
        apply_reset();
        set_pkt(1, 4, 2, 1'b0);
        drive_inputs();
        for (int k = 0; k < 8; k++) begin
            step();
            if (obs_all !== exp_all) begin
                n_fail++; $display("FAIL basic_model k=%0d got %h want %h", k, obs_all, exp_all);
            end
            n_tests++;
            if (m_grant_valid[2] !== (k <= 3) || m_in_grant[1] !== (k <= 3) ||
                (k <= 3 && m_grant_sel[2*SELW +: SELW] !== 2'd1)) begin
                n_fail++;
                $display("FAIL basic_window k=%0d valid2=%b ingrant1=%b sel2=%0d want valid=%b sel=1",
                         k, m_grant_valid[2], m_in_grant[1], m_grant_sel[2*SELW +: SELW], (k <= 3));
            end
            n_tests++;
        end
    endtask

    task automatic test_contention();
        int last_k;
        logic prev;
        logic [N-1:0] got;
        logic [N-1:0] want;
        apply_reset();
        for (int i = 0; i < N; i++) set_pkt(i, 1, 0, 1'b1);
        exp_q = {3'd0, 3'd1, 3'd2, 3'd0};
        drive_inputs();
        last_k = -1;
        prev   = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (obs_all !== exp_all) begin
                n_fail++; $display("FAIL contention_model k=%0d got %h want %h", k, obs_all, exp_all);
            end
            n_tests++;
            if (m_grant_valid[0] && !prev && exp_q.size() > 0) begin
                got  = N'(m_grant_sel[0 +: SELW]);
                want = exp_q.pop_front();
                if (got !== want || (last_k >= 0 && k - last_k != 2)) begin
                    n_fail++;
                    $display("FAIL contention_order k=%0d got sel %0d gap %0d want sel %0d gap 2",
                             k, got, k - last_k, want);
                end
                n_tests++;
                last_k = k;
            end
            prev = m_grant_valid[0];
        end
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL contention_missing got %0d grants want 4", 4 - exp_q.size());
        end
        n_tests++;
        for (int i = 0; i < N; i++) reload[i] = 1'b0;
    endtask

    task automatic test_stall();
        apply_reset();
        set_pkt(0, 4, 1, 1'b0);
        set_pkt(2, 2, 1, 1'b0);
        drive_inputs();
        for (int k = 0; k < 24; k++) begin
            ready[0] = !(k >= 1 && k < 11);
            step();
            if (obs_all !== exp_all) begin
                n_fail++; $display("FAIL stall_model k=%0d got %h want %h", k, obs_all, exp_all);
            end
            n_tests++;
            if (beats[0] > 0 && (m_grant_valid[1] !== 1'b1 || m_grant_sel[1*SELW +: SELW] !== 2'd0)) begin
                n_fail++;
                $display("FAIL stall_hold k=%0d valid1=%b sel1=%0d want 1/0",
                         k, m_grant_valid[1], m_grant_sel[1*SELW +: SELW]);
            end
            n_tests++;
        end
    endtask

    task automatic test_bad_tdest();
        apply_reset();
        set_pkt(0, 3, 2, 1'b1);
        set_pkt(1, 2, 256, 1'b0);
        set_pkt(2, 3, 5, 1'b0);
        drive_inputs();
        for (int k = 0; k < 8; k++) begin
            step();
            if (obs_all !== exp_all) begin
                n_fail++; $display("FAIL bad_tdest_model k=%0d got %h want %h", k, obs_all, exp_all);
            end
            n_tests++;
            if (dest_err[2] !== 1'b1 || dest_err[1] !== 1'b1 || m_in_grant[2:1] !== 2'b00) begin
                n_fail++;
                $display("FAIL bad_tdest k=%0d dest_err=%b in_grant=%b want err[2:1]=11 grant[2:1]=00",
                         k, dest_err, m_in_grant);
            end
            n_tests++;
        end
        reload[0] = 1'b0;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        set_pkt(0, 50, 0, 1'b0);
        set_pkt(1, 50, 1, 1'b0);
        drive_inputs();
        for (int k = 0; k < 3; k++) begin
            step();
            if (obs_all !== exp_all) begin
                n_fail++; $display("FAIL reset_mid_model k=%0d got %h want %h", k, obs_all, exp_all);
            end
            n_tests++;
        end
        rst = 1'b1;
        set_pkt(2, 1, 0, 1'b0);
        drive_inputs();
        step();
        if (obs_all !== '0) begin
            n_fail++; $display("FAIL reset_mid_clear got %h want 0", obs_all);
        end
        n_tests++;
        rst = 1'b0;
        step();
        if (m_grant_valid[1:0] !== 2'b11 || m_grant_sel[0 +: SELW] !== 2'd0 ||
            m_grant_sel[SELW +: SELW] !== 2'd1) begin
            n_fail++;
            $display("FAIL reset_mid_rearb valid=%b sel=%h want valid[1:0]=11 sel0=0 sel1=1",
                     m_grant_valid, m_grant_sel);
        end
        n_tests++;
        for (int k = 0; k < 4; k++) begin
            step();
            if (obs_all !== exp_all) begin
                n_fail++; $display("FAIL reset_mid_after k=%0d got %h want %h", k, obs_all, exp_all);
            end
            n_tests++;
        end
    endtask

`ifdef CROSSBAR_ARB_WATCHDOG_EN
    task automatic test_watchdog();
        apply_reset();
        set_pkt(0, 4, 2, 1'b0);
        set_pkt(1, 1, 2, 1'b0);
        drive_inputs();
        for (int k = 0; k < 14; k++) begin
            ready[0] = (k == 0);
            step();
            if (obs_all !== exp_all) begin
                n_fail++; $display("FAIL watchdog_model k=%0d got %h want %h", k, obs_all, exp_all);
            end
            n_tests++;
            if (wd_release[2] !== (k == 9)) begin
                n_fail++; $display("FAIL watchdog_pulse k=%0d got %b want %b", k, wd_release[2], (k == 9));
            end
            n_tests++;
            if (k == 10 && (m_grant_valid[2] !== 1'b1 || m_grant_sel[2*SELW +: SELW] !== 2'd1)) begin
                n_fail++;
                $display("FAIL watchdog_regrant valid2=%b sel2=%0d want 1/1",
                         m_grant_valid[2], m_grant_sel[2*SELW +: SELW]);
            end
            if (k == 10) n_tests++;
        end
    endtask
`else
    task automatic test_watchdog();
        apply_reset();
        set_pkt(0, 4, 2, 1'b0);
        set_pkt(1, 1, 2, 1'b0);
        drive_inputs();
        for (int k = 0; k < 30; k++) begin
            ready[0] = (k == 0);
            step();
            if (obs_all !== exp_all) begin
                n_fail++; $display("FAIL no_watchdog_model k=%0d got %h want %h", k, obs_all, exp_all);
            end
            n_tests++;
            if (wd_release !== '0 || m_grant_valid[2] !== 1'b1 || m_grant_sel[2*SELW +: SELW] !== 2'd0) begin
                n_fail++;
                $display("FAIL no_watchdog_hold k=%0d wd=%b valid2=%b sel2=%0d want 0/1/0",
                         k, wd_release, m_grant_valid[2], m_grant_sel[2*SELW +: SELW]);
            end
            n_tests++;
        end
    endtask
`endif

    task automatic test_random();
        apply_reset();
        raw_mode = 1'b1;
        drive_inputs();
        for (int k = 0; k < 500; k++) begin
            step();
            if (obs_all !== exp_all) begin
                n_fail++; $display("FAIL random_model k=%0d got %h want %h", k, obs_all, exp_all);
            end
            n_tests++;
        end
        raw_mode = 1'b0;
    endtask

    // ---------------- main sequence and report ----------------
    initial begin
        rst = 1'b1;
        s_req_tvalid  = '0;
        s_req_tdest   = '0;
        s_req_tlast   = '0;
        s_req_taccept = '0;
        raw_mode      = 1'b0;
        for (int j = 0; j < M; j++) begin
            own[j] = -1; ptr[j] = 0; stall[j] = 0;
        end
        test_reset();
        test_basic_grant();
        test_contention();
        test_stall();
        test_bad_tdest();
        test_reset_mid();
        test_watchdog();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
